// File: rtl/gmii_rx_parser.sv
// GMII receive parser: strips preamble/SFD, filters IPv4/UDP frames for one
// destination port, decodes the 2-byte application header and packs payload
// bytes into 48-bit video words or 25-bit audio words for the receive FIFOs.
module gmii_rx_parser #(
  parameter logic [15:0] UDP_PORT  = 16'd12345,
  parameter logic [15:0] ETHERTYPE = 16'h0800
) (
  input  logic        rx_clk,
  input  logic        sys_rst,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  input  logic        vfull,
  input  logic        afull,
  output logic [47:0] vdin,
  output logic        vwr_en,
  output logic [24:0] adin,
  output logic        awr_en,
  output logic        rx_id,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] drop_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_APP, S_PAY, S_DRAIN} state_t;

  state_t      state, state_n;
  logic [5:0]  hdr_cnt;    // byte offset after SFD, 0..43
  logic [7:0]  word_cnt;
  logic [7:0]  word_num;
  logic [2:0]  byte_cnt;
  logic        is_audio;
  logic        type_id;
  logic [39:0] shift;      // previous five payload bytes
  logic        hdr_ok;
  logic        word_last;
  logic        word_end;
  logic        word_full;
  logic        err_n;
  logic        done_n;

  // State register
  always_ff @(posedge rx_clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_n;
  end

  // Next-state decode, header field checks and frame event detection
  always_comb begin
    state_n   = state;
    err_n     = 1'b0;
    word_end  = 1'b0;
    word_last = (byte_cnt == (is_audio ? 3'd3 : 3'd5));
    word_full = is_audio ? afull : vfull;
    case (hdr_cnt)
      6'd12:   hdr_ok = (rxd == ETHERTYPE[15:8]);
      6'd13:   hdr_ok = (rxd == ETHERTYPE[7:0]);
      6'd23:   hdr_ok = (rxd == 8'h11);
      6'd36:   hdr_ok = (rxd == UDP_PORT[15:8]);
      6'd37:   hdr_ok = (rxd == UDP_PORT[7:0]);
      default: hdr_ok = 1'b1;
    endcase
    case (state)
      S_IDLE: begin
        if (rx_dv) state_n = (!rx_er && rxd == 8'h55) ? S_PRE : S_DRAIN;
      end
      S_PRE: begin
        if (!rx_dv)             state_n = S_IDLE;
        else if (rx_er)         state_n = S_DRAIN;
        else if (rxd == 8'hD5)  state_n = S_HDR;
        else if (rxd != 8'h55)  state_n = S_DRAIN;
      end
      S_HDR: begin
        if (!rx_dv) state_n = S_IDLE;
        else if (rx_er) begin
          state_n = S_DRAIN;
          err_n   = 1'b1;
        end
        else if (!hdr_ok)           state_n = S_DRAIN;
        else if (hdr_cnt == 6'd41)  state_n = S_APP;
      end
      S_APP: begin
        if (!rx_dv || rx_er) begin
          state_n = rx_dv ? S_DRAIN : S_IDLE;
          err_n   = 1'b1;
        end
        else if (hdr_cnt == 6'd43) begin
          state_n = (rxd == 8'd0) ? S_DRAIN : S_PAY;
          err_n   = (rxd == 8'd0);
        end
      end
      S_PAY: begin
        if (!rx_dv || rx_er) begin
          state_n = rx_dv ? S_DRAIN : S_IDLE;
          err_n   = 1'b1;
        end
        else if (word_last) begin
          word_end = 1'b1;
          if (word_cnt + 8'd1 == word_num) state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!rx_dv) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    done_n = word_end && (word_cnt + 8'd1 == word_num);
  end

  // Datapath: header capture, word assembly, FIFO strobes and drop counting
  always_ff @(posedge rx_clk) begin
    if (sys_rst) begin
      hdr_cnt    <= '0;
      word_cnt   <= '0;
      word_num   <= '0;
      byte_cnt   <= '0;
      is_audio   <= 1'b0;
      type_id    <= 1'b0;
      shift      <= '0;
      vdin       <= '0;
      vwr_en     <= 1'b0;
      adin       <= '0;
      awr_en     <= 1'b0;
      rx_id      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      drop_cnt   <= '0;
    end
    else begin
      vwr_en     <= 1'b0;
      awr_en     <= 1'b0;
      frame_done <= done_n;
      frame_err  <= err_n;
      if (state == S_PRE)
        hdr_cnt <= '0;
      else if (rx_dv && (state == S_HDR || state == S_APP))
        hdr_cnt <= hdr_cnt + 6'd1;
      if (state == S_APP && rx_dv && !rx_er) begin
        if (hdr_cnt == 6'd42) begin
          is_audio <= rxd[0];
          type_id  <= rxd[7];
        end
        if (hdr_cnt == 6'd43) begin
          rx_id    <= type_id;
          word_num <= rxd;
        end
      end
      if (state == S_APP && state_n == S_PAY) begin
        word_cnt <= '0;
        byte_cnt <= '0;
      end
      else if (state == S_PAY && rx_dv) begin
        shift <= {shift[31:0], rxd};
        if (word_end) begin
          byte_cnt <= '0;
          word_cnt <= word_cnt + 8'd1;
          if (word_full) begin
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
          end
          else if (is_audio) begin
            awr_en <= 1'b1;
            adin   <= {shift[16:0], rxd};
          end
          else begin
            vwr_en <= 1'b1;
            vdin   <= {shift, rxd};
          end
        end
        else if (!rx_er) begin
          byte_cnt <= byte_cnt + 3'd1;
        end
      end
    end
  end

endmodule
